img_loader_121: RTL and testbench
=================================

// Module: img_loader_121
// PURPOSE
//  Upstream feeder for the 121-16-10 TCB inference top.
//  Deserialises one 8-bit pixel per cycle from a stream into an 11x11 (121-pixel) image vector and pulses the network start.
//  Captures the network's predicted class when the network signals done, and returns it on a result handshake.
//  Stays one image per inference: the next image is not accepted until the result is taken.
// PARAMETERS
//  N_PIX    121   pixels per image
//  PIX_W    8     bits per pixel
//  RES_W    32    width of predicted class
//  WAIT_MAX 4096  max cycles in WAIT before timeout (counter width $clog2(WAIT_MAX+1))
//  BIN_THR  128   binarisation threshold (used only with PIX_BIN_EN)
// PORTS
//  clk          in   1              clock, all logic on rising edge
//  rst          in   1              synchronous reset, active-low
//  pix_in       in   PIX_W          pixel data
//  pix_valid    in   1              pixel present
//  pix_last     in   1              marks final pixel of a frame
//  pix_ready    out  1              loader accepts pixel
//  img_out      out  N_PIX*PIX_W    image; pixel k (k=0 first received) at [k*PIX_W +: PIX_W]
//  net_valid    out  1              one-cycle start pulse to network
//  net_ready    in   1              network done (pulse or level)
//  net_predict  in   RES_W          network predicted class, valid with net_ready
//  res_valid    out  1              result available
//  res_ready    in   1              result consumer accepts
//  res_class    out  RES_W          captured class; all-ones on timeout
//  frame_err    out  1              sticky: malformed frame or timeout
// BEHAVIOUR
//  Reset (rst==0 at clk edge)
//   - state=LOAD, cnt=0, buffer all 0.
//   - pix_ready=0 in reset cycle, net_valid=0, res_valid=0, res_class=0, frame_err=0.
//   - Applies from any state, including mid-frame and WAIT; any partial frame is discarded.
//  States
//   - LOAD
//     - pix_ready=1. Accept on pix_valid&pix_ready: buf[cnt]<=pix, cnt++.
//     - Accept with cnt==N_PIX-1 and pix_last=1: go to START, cnt=0.
//     - Accept with cnt==N_PIX-1 and pix_last=0: set frame_err, go to DRAIN.
//     - Accept with cnt<N_PIX-1 and pix_last=1: set frame_err, cnt=0, stay LOAD. The frame is dropped and the buffer keeps stale data.
//   - DRAIN
//     - pix_ready=1. Discard pixels until one with pix_last=1 is accepted, then go to START with the buffered image.
//   - START
//     - net_valid=1 for exactly this cycle, pix_ready=0, then go to WAIT with the timer cleared.
//   - WAIT
//     - pix_ready=0, timer++.
//     - net_ready=1: res_class<=net_predict, go to RESULT.
//     - Timer reaches WAIT_MAX before net_ready: res_class<=all-ones, set frame_err, go to RESULT.
//   - RESULT
//     - res_valid=1, res_class stable. On res_ready: go to LOAD, cnt=0.
//  Handshakes and timing
//   - net_ready outside WAIT is ignored.
//   - res_ready outside RESULT is ignored.
//   - img_out is the registered buffer. It is unchanged from START through RESULT.
//  Latency
//   - Last pixel accepted at cycle T: net_valid high at T+1.
//   - net_ready sampled at cycle W: res_valid high at W+1.
//   - res_ready at cycle R: pix_ready high at R+1.
//  Other rules
//   - frame_err clears only on reset.
//   - cnt is $clog2(N_PIX) bits wide and never exceeds N_PIX-1.
// CONFIGURATION
//  PIX_BIN_EN defined
//   - Each pixel is stored as 8'hFF when pix_in>=BIN_THR, else 8'h00. The comparison is unsigned.
//   - Affects stored data only, not timing.
//  PIX_BIN_EN undefined
//   - pix_in is stored verbatim and BIN_THR is unused.
// TESTING
//  1. Stream 121 pixels with value=k%256 and pix_last on the 121st.
//     -> img_out[k*8+:8]==k. net_valid high for 1 cycle at T+1.
//     -> Drive net_ready with net_predict=7: res_class=7, res_valid=1.
//  2. Send pix_last on the 50th pixel.
//     -> frame_err=1, no net_valid, cnt restarts.
//     -> A following good frame completes normally.
//  3. Send 130 pixels with pix_last on the 130th.
//     -> frame_err=1.
//     -> net_valid one cycle after the 130th is accepted; img_out holds the first 121.
//  4. Hold net_ready=0 for WAIT_MAX cycles.
//     -> res_class=32'hFFFFFFFF, frame_err=1, res_valid=1.
//  5. Hold res_ready=0 for 20 cycles while pix_valid=1.
//     -> pix_ready stays 0 and res_class stays stable.
//     -> res_ready pulse: pix_ready=1 on the next cycle.
//  6. Assert rst=0 mid-frame (cnt=60) and again in WAIT.
//     -> All outputs 0 next cycle, buffer cleared, back in LOAD.
//     -> With PIX_BIN_EN, pixels 127/128 store 00/FF.

Source files
------------

// File: rtl/img_loader_121_if.sv
// Stream, network and result signals of the 121-pixel image loader.
// master = environment side, slave = loader side.
interface img_loader_121_if #(
    parameter int N_PIX = 121,
    parameter int PIX_W = 8,
    parameter int RES_W = 32
);
    logic [PIX_W-1:0]       pix_in;
    logic                   pix_valid;
    logic                   pix_last;
    logic                   pix_ready;
    logic [N_PIX*PIX_W-1:0] img_out;
    logic                   net_valid;
    logic                   net_ready;
    logic [RES_W-1:0]       net_predict;
    logic                   res_valid;
    logic                   res_ready;
    logic [RES_W-1:0]       res_class;
    logic                   frame_err;

    modport master (
        output pix_in, pix_valid, pix_last, net_ready, net_predict, res_ready,
        input  pix_ready, img_out, net_valid, res_valid, res_class, frame_err
    );

    modport slave (
        input  pix_in, pix_valid, pix_last, net_ready, net_predict, res_ready,
        output pix_ready, img_out, net_valid, res_valid, res_class, frame_err
    );
endinterface

// File: rtl/img_loader_121.sv
// Pixel-stream deserialiser feeding one 11x11 image per inference and returning the class.
// Optional macro PIX_BIN_EN: store pixels binarised against BIN_THR (8'hFF / 8'h00).
module img_loader_121 #(
    parameter int N_PIX    = 121,
    parameter int PIX_W    = 8,
    parameter int RES_W    = 32,
    parameter int WAIT_MAX = 4096,
    parameter int BIN_THR  = 128
) (
    input  logic               clk,
    input  logic               rst,
    img_loader_121_if.slave    bus
);
    localparam int CNT_W = $clog2(N_PIX);
    localparam int TMR_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {S_LOAD, S_DRAIN, S_START, S_WAIT, S_RESULT} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q;
    logic [TMR_W-1:0]               timer_q;
    logic [N_PIX-1:0][PIX_W-1:0]    img_q;
    logic [RES_W-1:0]               res_class_q;
    logic                           frame_err_q;
    logic                           pix_rdy, net_vld, res_vld;
    logic                           accept, last_slot, timeout;
    logic [PIX_W-1:0]               pix_store;

`ifdef PIX_BIN_EN
    assign pix_store = (int'(bus.pix_in) >= BIN_THR) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
    logic unused_bin_thr;
    assign pix_store      = bus.pix_in;
    assign unused_bin_thr = (BIN_THR != 0);
`endif

    assign accept    = bus.pix_valid & pix_rdy;
    assign last_slot = (cnt_q == CNT_W'(N_PIX - 1));
    assign timeout   = (timer_q == TMR_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_LOAD;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   if (accept && last_slot) state_d = bus.pix_last ? S_START : S_DRAIN;
            S_DRAIN:  if (accept && bus.pix_last) state_d = S_START;
            S_START:  state_d = S_WAIT;
            S_WAIT:   if (bus.net_ready || timeout) state_d = S_RESULT;
            S_RESULT: if (bus.res_ready) state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
    end

    // Outputs are forced low while reset is asserted, whatever the state.
    always_comb begin
        pix_rdy = 1'b0;
        net_vld = 1'b0;
        res_vld = 1'b0;
        if (rst) begin
            case (state_q)
                S_LOAD, S_DRAIN: pix_rdy = 1'b1;
                S_START:         net_vld = 1'b1;
                S_RESULT:        res_vld = 1'b1;
                default:         ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            timer_q     <= '0;
            img_q       <= '0;
            res_class_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: if (accept) begin
                    img_q[cnt_q] <= pix_store;
                    if (last_slot) begin
                        cnt_q <= '0;
                        if (!bus.pix_last) frame_err_q <= 1'b1;
                    end else if (bus.pix_last) begin
                        // Short frame: dropped, buffer keeps whatever was written.
                        cnt_q       <= '0;
                        frame_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_START: timer_q <= '0;
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (bus.net_ready) begin
                        res_class_q <= bus.net_predict;
                    end else if (timeout) begin
                        res_class_q <= '1;
                        frame_err_q <= 1'b1;
                    end
                end
                S_RESULT: if (bus.res_ready) cnt_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.pix_ready = pix_rdy;
    assign bus.net_valid = net_vld;
    assign bus.res_valid = res_vld;
    assign bus.img_out   = img_q;
    assign bus.res_class = res_class_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_img_loader_121.sv
// Directed bench for img_loader_121 with a result scoreboard and a bench-side image model.
module tb_img_loader_121;
    localparam int N_PIX    = 121;
    localparam int WAIT_MAX = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    img_loader_121_if #(.N_PIX(N_PIX), .PIX_W(8), .RES_W(32)) ifc ();

    img_loader_121 #(.N_PIX(N_PIX), .PIX_W(8), .RES_W(32), .WAIT_MAX(WAIT_MAX), .BIN_THR(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [7:0]  exp_img [N_PIX];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] stored(input logic [7:0] v);
`ifdef PIX_BIN_EN
        return (v >= 8'd128) ? 8'hFF : 8'h00;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] pix_val(input int kind, input int k);
        case (kind)
            0:       return 8'(k % 256);
            1:       return 8'((k * 3 + 1) % 256);
            2:       return 8'(255 - k);
            default: return (k == 0) ? 8'd127 : (k == 1) ? 8'd128 : 8'(k + 10);
        endcase
    endfunction

    function automatic int img_bad();
        int bad = 0;
        for (int k = 0; k < N_PIX; k++)
            if (ifc.img_out[k*8 +: 8] !== exp_img[k]) bad++;
        return bad;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        for (int k = 0; k < N_PIX; k++) exp_img[k] = 8'h00;
        chk("rst_pix_ready", ifc.pix_ready, 0);
        chk("rst_net_valid", ifc.net_valid, 0);
        chk("rst_res_valid", ifc.res_valid, 0);
        chk("rst_res_class", ifc.res_class, 0);
        chk("rst_frame_err", ifc.frame_err, 0);
        chk("rst_img_bad", img_bad(), 0);
        rst = 1'b1;
        #1;
        chk("rst_release_pix_ready", ifc.pix_ready, 1);
    endtask

    task automatic send_pix(input logic [7:0] v, input logic last);
        int n = 0;
        while (ifc.pix_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (ifc.pix_ready !== 1'b1) chk("pix_ready_wait", ifc.pix_ready, 1);
        ifc.pix_in    = v;
        ifc.pix_valid = 1'b1;
        ifc.pix_last  = last;
        tick();
        ifc.pix_valid = 1'b0;
        ifc.pix_last  = 1'b0;
    endtask

    // Full 121-pixel frame; leaves the DUT in WAIT after checking the start pulse.
    task automatic send_frame(input int kind, input string tag);
        for (int k = 0; k < N_PIX; k++) begin
            exp_img[k] = stored(pix_val(kind, k));
            if (k == N_PIX - 1) chk({tag, "_nv_before_last"}, ifc.net_valid, 0);
            send_pix(pix_val(kind, k), k == N_PIX - 1);
        end
        chk({tag, "_net_valid_T1"}, ifc.net_valid, 1);
        chk({tag, "_img"}, img_bad(), 0);
        tick();
        chk({tag, "_net_valid_pulse"}, ifc.net_valid, 0);
    endtask

    task automatic respond(input logic [31:0] p, input string tag);
        ifc.net_ready   = 1'b1;
        ifc.net_predict = p;
        exp_q.push_back(p);
        tick();
        ifc.net_ready   = 1'b0;
        ifc.net_predict = 32'h0;
        chk({tag, "_res_valid_W1"}, ifc.res_valid, 1);
    endtask

    task automatic collect(input string tag);
        int n = 0;
        logic [31:0] e;
        while (ifc.res_valid !== 1'b1 && n < WAIT_MAX + 50) begin
            tick();
            n++;
        end
        chk({tag, "_res_valid"}, ifc.res_valid, 1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_res_class"}, ifc.res_class, e);
        end
        ifc.res_ready = 1'b1;
        tick();
        ifc.res_ready = 1'b0;
        chk({tag, "_pix_ready_R1"}, ifc.pix_ready, 1);
    endtask

    initial begin
        int bad;
        int cyc;
        logic [31:0] rc0;
        ifc.pix_in = '0; ifc.pix_valid = 1'b0; ifc.pix_last = 1'b0;
        ifc.net_ready = 1'b0; ifc.net_predict = '0; ifc.res_ready = 1'b0;

        // Good frame, then hold the result while pixels are offered.
        do_reset();
        send_frame(0, "t1");
        respond(32'd7, "t1");
        rc0 = 32'd7;
        bad = 0;
        ifc.pix_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ifc.pix_ready !== 1'b0 || ifc.res_class !== rc0 || ifc.res_valid !== 1'b1) bad++;
        end
        ifc.pix_valid = 1'b0;
        chk("t5_hold_stable", bad, 0);
        chk("t1_img_held", img_bad(), 0);
        collect("t1");
        chk("t1_frame_err", ifc.frame_err, 0);

        // Short frame (last on 50th), then a good frame.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            exp_img[k] = stored(pix_val(2, k));
            send_pix(pix_val(2, k), k == 49);
        end
        chk("t2_frame_err", ifc.frame_err, 1);
        chk("t2_no_net_valid", ifc.net_valid, 0);
        chk("t2_pix_ready", ifc.pix_ready, 1);
        send_frame(1, "t2");
        respond(32'h1234_5678, "t2");
        collect("t2");

        // Long frame: 130 pixels, last on the 130th.
        do_reset();
        for (int k = 0; k < 130; k++) begin
            if (k < N_PIX) exp_img[k] = stored(pix_val(2, k));
            send_pix(pix_val(2, k % 256), k == 129);
            if (k == N_PIX + 2) chk("t3_no_net_valid_drain", ifc.net_valid, 0);
        end
        chk("t3_net_valid", ifc.net_valid, 1);
        chk("t3_frame_err", ifc.frame_err, 1);
        chk("t3_img_first121", img_bad(), 0);
        tick();
        respond(32'd42, "t3");
        collect("t3");

        // Network never answers: timeout after WAIT_MAX cycles in WAIT.
        do_reset();
        for (int k = 0; k < N_PIX; k++) begin
            exp_img[k] = stored(pix_val(0, k));
            send_pix(pix_val(0, k), k == N_PIX - 1);
        end
        chk("t4_net_valid", ifc.net_valid, 1);
        exp_q.push_back(32'hFFFF_FFFF);
        cyc = 0;
        while (ifc.res_valid !== 1'b1 && cyc < WAIT_MAX + 20) begin
            tick();
            cyc++;
        end
        chk("t4_timeout_cycles", cyc, WAIT_MAX + 1);
        chk("t4_frame_err", ifc.frame_err, 1);
        collect("t4");

        // Reset mid-frame at cnt=60, then reset while in WAIT.
        do_reset();
        for (int k = 0; k < 60; k++) send_pix(pix_val(0, k), 1'b0);
        do_reset();
        send_frame(1, "t6");
        tick();
        do_reset();
        chk("t6_no_result", ifc.res_valid, 0);
        send_frame(3, "t6b");
        chk("t6_bin_p0", ifc.img_out[7:0], stored(8'd127));
        chk("t6_bin_p1", ifc.img_out[15:8], stored(8'd128));
        respond(32'd3, "t6");
        collect("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
